// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: md_op encodings, default
// latencies, counter width and the IDLE/RUN state type.
// Optional feature macro used by the files importing this package:
//   MDU_MADD_EN - enables MADD/MADDU (ops 6/7) as multi-cycle accumulates.
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_e;

    localparam int MDU_MULT_LAT_DEF = 5;
    localparam int MDU_DIV_LAT_DEF  = 10;
    localparam int MDU_CNT_W        = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Purely combinational result generator for the multiply/divide unit. Given
// the latched op and operands plus the current HI/LO, it produces the value
// {HI,LO} will take at commit.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into {HI,LO}).
// Ports:
//   op_i        latched md_op
//   a_i, b_i    latched rs / rt operands
//   hi_i, lo_i  current HI / LO
//   hi_o, lo_o  HI / LO value to commit
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] hiLo;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] divisor;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] quoMag;
    logic [31:0] remMag;
    logic [31:0] quoS;
    logic [31:0] remS;
    logic [31:0] quoU;
    logic [31:0] remU;
    logic        divByZero;

    assign hiLo  = {hi_i, lo_i};
    assign prodS = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prodU = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is replaced by 1 so the dividers never see zero; the
    // result is discarded anyway because HI/LO are held on divide-by-zero.
    assign divByZero = (b_i == 32'd0);
    assign divisor   = divByZero ? 32'd1 : b_i;

    // Signed division via magnitudes. 0x80000000 has magnitude 0x80000000 as
    // an unsigned value, so 0x80000000 / -1 naturally yields LO=0x80000000,
    // HI=0 with no special case.
    assign aMag   = a_i[31] ? -a_i : a_i;
    assign bMag   = divisor[31] ? -divisor : divisor;
    assign quoMag = aMag / bMag;
    assign remMag = aMag % bMag;
    assign quoS   = (a_i[31] ^ divisor[31]) ? -quoMag : quoMag;
    assign remS   = a_i[31] ? -remMag : remMag;

    assign quoU = a_i / divisor;
    assign remU = a_i % divisor;

    // Result selection; anything that is not a real arithmetic op holds.
    always_comb begin
        {hi_o, lo_o} = hiLo;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prodS;
            MD_MULTU: {hi_o, lo_o} = prodU;
            MD_DIV:   if (!divByZero) {hi_o, lo_o} = {remS, quoS};
            MD_DIVU:  if (!divByZero) {hi_o, lo_o} = {remU, quoU};
`ifdef MDU_MADD_EN
            MD_MADD:  {hi_o, lo_o} = hiLo + prodS;
            MD_MADDU: {hi_o, lo_o} = hiLo + prodU;
`endif
            default:  {hi_o, lo_o} = hiLo;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
// EX-stage multiply/divide unit. Executes MULT/MULTU/DIV/DIVU (and MADD/MADDU
// when enabled) over a fixed number of cycles, owns HI/LO and reports busy to
// the hazard unit. MTHI/MTLO write HI/LO in a single cycle when idle.
// Optional feature macro: MDU_MADD_EN (ops 6/7 become multi-cycle
// accumulates; otherwise they are no-ops).
// Parameters:
//   MULT_LAT  busy cycles for multiply ops (1..15)
//   DIV_LAT   busy cycles for divide ops (1..15)
// Ports:
//   clk       clock, all state updates on posedge
//   reset     asynchronous active-high reset
//   md_start  issue an MD operation this cycle
//   md_op     operation code (see mdu_pkg::md_op_e)
//   md_wr     MTHI/MTLO strobe
//   rs_val    forwarded GPR[rs]
//   rt_val    forwarded GPR[rt]
//   busy      operation in flight
//   hi_out    current HI
//   lo_out    current LO
// ---------------------------------------------------------------------------
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic        md_wr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [MDU_CNT_W-1:0] MulLatC = MULT_LAT[MDU_CNT_W-1:0];
    localparam logic [MDU_CNT_W-1:0] DivLatC = DIV_LAT[MDU_CNT_W-1:0];
    localparam logic [MDU_CNT_W-1:0] CntOne  = {{(MDU_CNT_W-1){1'b0}}, 1'b1};

    mdu_state_e           state_q;
    logic [MDU_CNT_W-1:0] cnt_q;
    md_op_e               op_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [31:0]          hi_q;
    logic [31:0]          lo_q;
    logic [31:0]          hi_d;
    logic [31:0]          lo_d;
    md_op_e               opIn;
    logic                 issueOk;
    logic [MDU_CNT_W-1:0] issueLat;

    assign opIn = md_op_e'(md_op);

    // Decide whether md_start with this op launches a multi-cycle operation
    // and which latency it loads; MTHI/MTLO (and disabled MADD) do not.
    always_comb begin
        issueOk  = 1'b0;
        issueLat = '0;
        case (opIn)
            MD_MULT, MD_MULTU: begin
                issueOk  = 1'b1;
                issueLat = MulLatC;
            end
            MD_DIV, MD_DIVU: begin
                issueOk  = 1'b1;
                issueLat = DivLatC;
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                issueOk  = 1'b1;
                issueLat = MulLatC;
            end
`endif
            default: begin
                issueOk  = 1'b0;
                issueLat = '0;
            end
        endcase
    end

    mdu_arith u_arith (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (hi_d),
        .lo_o (lo_d)
    );

    // IDLE: accept an issue (md_start wins over md_wr) or an MTHI/MTLO write.
    // RUN: count down on latched operands and commit on the 1->0 step; any
    // md_start/md_wr seen while running is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_start) begin
                        if (issueOk) begin
                            op_q    <= opIn;
                            a_q     <= rs_val;
                            b_q     <= rt_val;
                            cnt_q   <= issueLat;
                            state_q <= ST_RUN;
                        end
                    end else if (md_wr) begin
                        if (opIn == MD_MTHI) hi_q <= rs_val;
                        if (opIn == MD_MTLO) lo_q <= rs_val;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
